// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns / InvMixColumns engine.
// One shared datapath sweeps COLS_PER_CYC columns of the state per cycle.
module mix_columns_seq #(
   parameter int COLS_PER_CYC = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_bypass,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int NPASS = 4 / COLS_PER_CYC;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       st;
   state_t       st_nxt;
   logic [1:0]   col_cnt;
   logic [127:0] data_q;
   logic         inv_q;
   logic         accept;
   logic         last;
   logic [31:0]  mixed [COLS_PER_CYC];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse coefficients e/b/d/9 are sums of the x2/x4/x8 chain.
   function automatic logic [31:0] mix_col(input logic [31:0] c,
                                           input logic inv);
      logic [7:0] s  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] r  [4];
      logic [1:0] j1, j2, j3;
      for (int i = 0; i < 4; i++) begin
         s[i]  = c[31-8*i -: 8];
         x2[i] = xt(s[i]);
         x4[i] = xt(x2[i]);
         x8[i] = xt(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
         j1 = 2'(i + 1);
         j2 = 2'(i + 2);
         j3 = 2'(i + 3);
         if (!inv)
            r[i] = x2[i] ^ x2[j1] ^ s[j1] ^ s[j2] ^ s[j3];
         else
            r[i] = (x8[i] ^ x4[i] ^ x2[i])
                 ^ (x8[j1] ^ x2[j1] ^ s[j1])
                 ^ (x8[j2] ^ x4[j2] ^ s[j2])
                 ^ (x8[j3] ^ s[j3]);
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction

   assign accept    = in_valid & in_ready;
   assign last      = (int'(col_cnt) == NPASS - 1);
   assign out_valid = (st == DONE);
   assign busy      = (st == BUSY);
   assign out_data  = data_q;

   always_comb begin
      for (int j = 0; j < COLS_PER_CYC; j++)
         mixed[j] = mix_col(
            data_q[32*(3 - (int'(col_cnt)*COLS_PER_CYC + j)) +: 32],
            inv_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         st <= IDLE;
      else
         st <= st_nxt;
   end

   always_comb begin
      st_nxt   = st;
      in_ready = 1'b0;
      unique case (st)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               st_nxt = in_bypass ? DONE : BUSY;
         end
         BUSY: begin
            if (last)
               st_nxt = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready)
               st_nxt = !in_valid ? IDLE : (in_bypass ? DONE : BUSY);
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         inv_q   <= 1'b0;
         col_cnt <= '0;
      end else if (accept) begin
         data_q  <= in_data;
         inv_q   <= in_inv;
         col_cnt <= '0;
      end else if (st == BUSY) begin
         for (int j = 0; j < COLS_PER_CYC; j++)
            data_q[32*(3 - (int'(col_cnt)*COLS_PER_CYC + j)) +: 32]
               <= mixed[j];
         col_cnt <= col_cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq at 1, 2 and 4 columns per cycle.
// Expected states are queued at drive time and popped on each output handshake.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_data   [3];
   logic         in_bypass [3];
   logic         in_inv    [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_data  [3];
   logic         busy      [3];

   logic [127:0] q0 [$];
   logic [127:0] q1 [$];
   logic [127:0] q2 [$];

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [127:0] FIPS_I = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_O = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] KC_I   = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] KC_O   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
   localparam logic [127:0] BY_I   = 128'hd4d4d4d52d26314c0000000011111111;
   localparam logic [127:0] B2_I   = {4{32'hd4d4d4d5}};
   localparam logic [127:0] B2_O   = {4{32'hd5d5d7d6}};

   always #5 clk = ~clk;

   mix_columns_seq #(.COLS_PER_CYC(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_bypass(in_bypass[0]), .in_inv(in_inv[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .busy(busy[0]));

   mix_columns_seq #(.COLS_PER_CYC(2)) u2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_bypass(in_bypass[1]), .in_inv(in_inv[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .busy(busy[1]));

   mix_columns_seq #(.COLS_PER_CYC(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .in_bypass(in_bypass[2]), .in_inv(in_inv[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .busy(busy[2]));

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: every result handshake pops one expected state.
   always @(negedge clk) begin
      if (out_valid[0] && out_ready[0]) begin
         if (q0.size() == 0) chk("unexp0", out_data[0], '0);
         else chk("out0", out_data[0], q0.pop_front());
      end
      if (out_valid[1] && out_ready[1]) begin
         if (q1.size() == 0) chk("unexp1", out_data[1], '0);
         else chk("out1", out_data[1], q1.pop_front());
      end
      if (out_valid[2] && out_ready[2]) begin
         if (q2.size() == 0) chk("unexp2", out_data[2], '0);
         else chk("out2", out_data[2], q2.pop_front());
      end
   end

   // Drive one block and return #1 after its accept edge.
   task automatic send(input int k, input logic [127:0] d,
                       input logic byp, input logic inv,
                       input logic [127:0] exp);
      bit ok = 0;
      case (k)
         0: q0.push_back(exp);
         1: q1.push_back(exp);
         default: q2.push_back(exp);
      endcase
      in_valid[k]  = 1'b1;
      in_data[k]   = d;
      in_bypass[k] = byp;
      in_inv[k]    = inv;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready[k]) ok = 1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid[k]  = 1'b0;
      in_data[k]   = ~d;
      in_bypass[k] = ~byp;
      in_inv[k]    = ~inv;
   endtask

   // Count edges from accept to out_valid, and busy cycles in between.
   task automatic wait_out(input int k, input int exp_lat,
                           input int exp_busy);
      int lat = 1;
      int bc  = 0;
      while (!out_valid[k] && lat < 20) begin
         if (busy[k]) bc++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("busy_cycles", bc, exp_busy);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         in_bypass[k] = 1'b0;
         in_inv[k]    = 1'b0;
         out_ready[k] = 1'b1;
      end
      #23;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ovalid", out_valid[k], 0);
         chk("rst_busy", busy[k], 0);
         chk("rst_odata", out_data[k], '0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk("rst_iready", in_ready[k], 1);

      send(0, FIPS_I, 0, 0, FIPS_O);
      wait_out(0, 5, 4);
      send(0, FIPS_O, 0, 1, FIPS_I);
      wait_out(0, 5, 4);
      send(0, KC_I, 0, 0, KC_O);
      wait_out(0, 5, 4);
      send(1, KC_I, 0, 0, KC_O);
      wait_out(1, 3, 2);
      send(2, KC_I, 0, 0, KC_O);
      wait_out(2, 2, 1);
      send(2, KC_O, 0, 1, KC_I);
      wait_out(2, 2, 1);
      send(1, FIPS_O, 0, 1, FIPS_I);
      wait_out(1, 3, 2);

      send(0, BY_I, 1, 0, BY_I);
      wait_out(0, 1, 0);
      @(posedge clk);
      #1;

      out_ready[0] = 1'b0;
      send(0, FIPS_I, 0, 0, FIPS_O);
      wait_out(0, 5, 4);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("hold_data", out_data[0], FIPS_O);
         chk("hold_iready", in_ready[0], 0);
      end
      out_ready[0] = 1'b1;
      send(0, B2_I, 0, 0, B2_O);
      chk("b2b_ovalid_drop", out_valid[0], 0);
      chk("b2b_busy", busy[0], 1);
      wait_out(0, 5, 4);
      @(posedge clk);
      #1;

      send(0, KC_I, 0, 0, KC_O);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q0.delete();
      #1;
      chk("mid_rst_ovalid", out_valid[0], 0);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_odata", out_data[0], '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_iready", in_ready[0], 1);
      chk("mid_rst_ovalid2", out_valid[0], 0);
      send(0, FIPS_I, 0, 0, FIPS_O);
      wait_out(0, 5, 4);

      repeat (4) @(posedge clk);
      #1;
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Iterative MixColumns controller: accepts a 128-bit AES state, runs it through one shared column-wide MixColumns/InvMixColumns datapath over several cycles, and returns the result.
- Sits between the ShiftRows stage and AddRoundKey in the round-iterative AES-128/256 core.
- Trades area for latency compared with the fully parallel combinational MixColumns.
- Supports a per-transaction bypass for the final round, where MixColumns is skipped.

Parameters:
- COLS_PER_CYC, 1, number of 32-bit columns processed per cycle. Legal values: 1, 2, 4. Passes per block NPASS = 4/COLS_PER_CYC.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input state valid
- in_ready  output  1  block can accept a state
- in_data  input  128  AES state. Column 0 = [127:96]; byte s0 of each column = the column's MSB byte.
- in_bypass  input  1  skip MixColumns (final round); sampled with in_data
- in_inv  input  1  apply InvMixColumns instead of MixColumns; sampled with in_data
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  128  transformed state, same byte order as in_data
- busy  output  1  high in BUSY state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, col_cnt=0, out_valid=0, busy=0, out_data=0, internal state register=0. in_ready=1 once rst_n=1. Reset mid-transaction discards the block with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load state register, latch bypass/inv, col_cnt=0.
  - Next state = DONE if bypass, else BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle replaces columns [col_cnt*COLS_PER_CYC +: COLS_PER_CYC] of the state register with their transformed values; col_cnt increments.
  - The pass with col_cnt==NPASS-1 transitions to DONE.
- DONE:
  - out_valid=1; out_data = state register, held stable while out_ready=0.
  - in_ready = out_ready, so a new input can be accepted in the same cycle the result drains.
  - On out_ready with no new accept: go to IDLE.
  - On out_ready together with in_valid: load the new block and go to BUSY, or stay in DONE for a bypass input. out_valid then deasserts for the BUSY case.
- Latency (accept edge to out_valid high): NPASS+1 cycles normally (5/3/2 for COLS_PER_CYC=1/2/4); 1 cycle with bypass.
- Throughput with out_ready held at 1: one block per NPASS+1 cycles.
- Column arithmetic, GF(2^8) mod x^8+x^4+x^3+x+1, xtime(b) = {b[6:0],1'b0} ^ (b[7]?8'h1b:0):
  - Forward MixColumns: r0 = 2s0^3s1^s2^s3, rotated for r1..r3.
  - InvMixColumns: coefficients e,b,d,9, built from chained xtime.
- Columns are independent; column order does not affect the result.
- Inputs sampled only on handshake. in_data/in_bypass/in_inv changes during BUSY are ignored.
- out_valid never drops without an out_ready handshake.

Test Plan:
- FIPS-197 round 1, COLS_PER_CYC=1, inv=0: in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=046681e5e0cb199a48f8d37a2806264c, out_valid rises 5 cycles after accept, busy high for 4 cycles.
- Inverse check: in_data=046681e5e0cb199a48f8d37a2806264c, inv=1 -> d4bf5d30e0b452aeb84111f11e2798e5.
- Known columns: in_data=db135345f20a225c01010101c6c6c6c6 -> 8e4da1bc9fdc589d01010101c6c6c6c6. Repeat for COLS_PER_CYC=2 and 4: same data, latency 3 and 2.
- Bypass: in_data=d4d4d4d52d26314c0000000011111111, bypass=1 -> identical out_data, out_valid 1 cycle after accept, busy never asserted.
- Backpressure/back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE: out_data stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 and a second vector (d4d4d4d5 column -> d5d5d7d6): both handshakes occur on the same edge and the second result is correct.
- Reset mid-BUSY: assert rst_n=0 at col_cnt=2 -> out_valid=0, in_ready=1 after release. The next vector processes correctly with no stale columns.
